// File: rtl/fmul_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fmul_pkg
// Purpose  : Shared constants and types for the pipelined FP32 multiplier
//            controller (pipeline depth, requester IDs, stage control record).
// Revision : 1.0  initial release
// ============================================================================
package fmul_pkg;

    // Registered stages between operand issue and the response register
    // (reg_mul_add, reg_add_normalize, response register).
    localparam int PIPE_DEPTH = 3;

    // Requester identifiers carried through the pipe.
    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    // Per-stage control record. The requester tag travels in a parallel
    // register because its width is a parameter of the top level.
    typedef struct packed {
        logic valid;
        logic id;
    } stage_ctl_t;

    localparam stage_ctl_t STAGE_EMPTY = '{valid: 1'b0, id: REQ0};

endpackage
`default_nettype wire

// File: rtl/fmul_pipe_ctrl_arb.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Purpose  : Two-way round-robin arbiter. A lone requester is granted
//            directly; when both request, the one not granted last wins.
//            The priority pointer moves only when the grant is accepted.
// Ports    : clk, rst      clock, synchronous active-high reset
//            i_valid[1:0]  request lines (bit n = requester n)
//            i_accept      the current grant was taken this cycle
//            o_grant[1:0]  one-hot grant (0 when nothing requests)
// Revision : 1.0  initial release
// ============================================================================
module rr_arb2
    import fmul_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_valid,
    input  logic       i_accept,
    output logic [1:0] o_grant
);

    // Requester that wins a tie on the next contested cycle.
    logic r_ptr;

    always_comb begin
        o_grant = i_valid;
        if (i_valid == 2'b11) begin
            o_grant = (r_ptr == REQ1) ? 2'b10 : 2'b01;
        end
    end

    // After granting req0 the tie goes to req1 and vice versa.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= REQ0;
        end else if (i_accept) begin
            r_ptr <= o_grant[REQ0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/fmul_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fmul_pipe_ctrl
// Purpose  : Sequencer/arbiter for the 3-stage pipelined FP32 multiplier.
//            Shares the multiplier between two requesters (round-robin),
//            tracks valid/ID/tag per stage, drives the stage-register
//            enables and owns the response register.
// Ports    : clk, rst                 clock, synchronous active-high reset
//            reqN_valid/ready/a/b/tag requester N handshake and operands
//            flush                    discard all in-flight operations
//            dp_a, dp_b               operands to the multiplier front stage
//            en_s1, en_s2             reg_mul_add / reg_add_normalize enables
//            dp_q                     normalize-stage result
//            rsp_valid/ready/q/id/tag response handshake and payload
//            busy                     any operation in flight
//            stall_cnt                saturating count of refused-request cycles
// Revision : 1.0  initial release
// ============================================================================
module fmul_pipe_ctrl
    import fmul_pkg::*;
#(
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    input  logic [TAG_W-1:0] req1_tag,
    input  logic             flush,
    output logic [31:0]      dp_a,
    output logic [31:0]      dp_b,
    output logic             en_s1,
    output logic             en_s2,
    input  logic [31:0]      dp_q,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_q,
    output logic             rsp_id,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             busy,
    output logic [CNT_W-1:0] stall_cnt
);

    stage_ctl_t       r_s1;         // reg_mul_add occupancy and owner
    stage_ctl_t       r_s2;         // reg_add_normalize occupancy and owner
    logic [TAG_W-1:0] r_tag1;
    logic [TAG_W-1:0] r_tag2;
    logic             r_v3;         // response register occupied
    logic [31:0]      r_rsp_q;
    logic             r_rsp_id;
    logic [TAG_W-1:0] r_rsp_tag;
    logic [CNT_W-1:0] r_stall_cnt;

    logic             w_out_free;
    logic             w_en_s3;
    logic             w_en_s2;
    logic             w_en_s1;
    logic [1:0]       w_grant;
    logic             w_grant_valid;
    logic             w_gid;
    logic             w_accept;
    logic             w_any_valid;
    logic [TAG_W-1:0] w_tag;

    // A stage may load whenever its current content moves on (or it is
    // empty). This lets bubbles collapse behind a stalled response.
    assign w_out_free = ~r_v3 | rsp_ready;
    assign w_en_s3    = w_out_free;
    assign w_en_s2    = ~r_s2.valid | w_out_free;
    assign w_en_s1    = ~r_s1.valid | w_en_s2;

    assign w_any_valid   = req0_valid | req1_valid;
    assign w_grant_valid = |w_grant;
    assign w_gid         = w_grant[REQ1];
    assign w_accept      = w_en_s1 & w_grant_valid & ~flush;

    rr_arb2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .i_valid  ({req1_valid, req0_valid}),
        .i_accept (w_accept),
        .o_grant  (w_grant)
    );

    // Operand/tag mux follows the grant; zero when nothing is granted.
    always_comb begin
        dp_a  = '0;
        dp_b  = '0;
        w_tag = '0;
        if (w_grant[REQ0]) begin
            dp_a  = req0_a;
            dp_b  = req0_b;
            w_tag = req0_tag;
        end else if (w_grant[REQ1]) begin
            dp_a  = req1_a;
            dp_b  = req1_b;
            w_tag = req1_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1      <= STAGE_EMPTY;
            r_s2      <= STAGE_EMPTY;
            r_tag1    <= '0;
            r_tag2    <= '0;
            r_v3      <= 1'b0;
            r_rsp_q   <= '0;
            r_rsp_id  <= REQ0;
            r_rsp_tag <= '0;
        end else begin
            if (w_en_s1) begin
                r_s1.valid <= w_accept;
                r_s1.id    <= w_gid;
                r_tag1     <= w_tag;
            end
            if (w_en_s2) begin
                r_s2   <= r_s1;
                r_tag2 <= r_tag1;
            end
            if (w_en_s3) begin
                r_v3      <= r_s2.valid;
                r_rsp_q   <= dp_q;
                r_rsp_id  <= r_s2.id;
                r_rsp_tag <= r_tag2;
            end
            // Flush overrides any shift: every occupancy bit drops at once.
            if (flush) begin
                r_s1.valid <= 1'b0;
                r_s2.valid <= 1'b0;
                r_v3       <= 1'b0;
            end
        end
    end

    // Counts cycles with a pending request that was refused; held during
    // flush and saturating at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (!flush && w_any_valid && !w_accept && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign req0_ready = w_accept & w_grant[REQ0];
    assign req1_ready = w_accept & w_grant[REQ1];
    assign en_s1      = w_en_s1;
    assign en_s2      = w_en_s2;
    assign rsp_valid  = r_v3;
    assign rsp_q      = r_rsp_q;
    assign rsp_id     = r_rsp_id;
    assign rsp_tag    = r_rsp_tag;
    assign busy       = r_s1.valid | r_s2.valid | r_v3;
    assign stall_cnt  = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fmul_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fmul_pipe_ctrl
// Purpose  : Self-checking bench for fmul_pipe_ctrl with a behavioural
//            multiplier datapath, transaction-level reference model and a
//            response scoreboard.
// Revision : 1.0  initial release
// ============================================================================
module tb_fmul_pipe_ctrl;

    localparam int TAG_W = 4;
    localparam int CNT_W = 5;
    localparam int STALL_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0]      req0_a, req0_b, req1_a, req1_b;
    logic [TAG_W-1:0] req0_tag, req1_tag;
    logic             flush;
    logic [31:0]      dp_a, dp_b, dp_q;
    logic             en_s1, en_s2;
    logic             rsp_valid, rsp_ready;
    logic [31:0]      rsp_q;
    logic             rsp_id;
    logic [TAG_W-1:0] rsp_tag;
    logic             busy;
    logic [CNT_W-1:0] stall_cnt;

    always #5 clk = ~clk;

    fmul_pipe_ctrl #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
        .req0_b(req0_b), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
        .req1_b(req1_b), .req1_tag(req1_tag),
        .flush(flush), .dp_a(dp_a), .dp_b(dp_b), .en_s1(en_s1), .en_s2(en_s2),
        .dp_q(dp_q), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_q(rsp_q), .rsp_id(rsp_id), .rsp_tag(rsp_tag),
        .busy(busy), .stall_cnt(stall_cnt)
    );

    // FP32 multiply for normal operands, mantissa truncated.
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] p;
        int          e;
        logic [22:0] m;
        p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) begin
            m = p[46:24];
            e = e + 1;
        end else begin
            m = p[45:23];
        end
        return {a[31] ^ b[31], 8'(e), m};
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [31:0] r;
        r = $urandom;
        r[30:23] = 8'($urandom_range(154, 100));
        return r;
    endfunction

    // Behavioural multiplier datapath: two enabled registers, normalize is
    // combinational from the second.
    logic [31:0] s1a, s1b, s2q;
    always_ff @(posedge clk) begin
        if (en_s1) begin
            s1a <= dp_a;
            s1b <= dp_b;
        end
        if (en_s2) s2q <= fmul(s1a, s1b);
    end
    assign dp_q = s2q;

    typedef struct packed {
        logic [31:0]      q;
        logic             id;
        logic [TAG_W-1:0] tag;
    } rsp_t;

    rsp_t sb[$];
    int   stg[$];     // reference model: stage (1..3) of each in-flight op, oldest first
    logic m_prio;     // requester favoured on the next tie
    int   m_stall;
    logic acc0_q, acc1_q;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: consumes expected responses when the DUT hands one over.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst && rsp_valid && rsp_ready) begin
                rsp_t e;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected actual=%0h expected=none", rsp_q);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_q", rsp_q, e.q);
                    chk("rsp_id", rsp_id, e.id);
                    chk("rsp_tag", rsp_tag, e.tag);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // One clock cycle: check predicted combinational/registered outputs,
    // then advance the reference model across the clock edge.
    task automatic tick();
        logic v0, v1, any, rr, fl, rs, g, can, acc, s3;
        logic [31:0] a, b;
        logic [TAG_W-1:0] t;
        int nq[$];
        bit occ[1:3];
        #1;
        v0 = req0_valid; v1 = req1_valid; any = v0 | v1;
        rr = rsp_ready; fl = flush; rs = rst;
        s3  = (stg.size() > 0) && (stg[0] == 3);
        can = (stg.size() < 3) || rr;
        g   = (v0 && v1) ? m_prio : !v0;
        acc = !rs && can && any && !fl;
        a = g ? req1_a : req0_a;
        b = g ? req1_b : req0_b;
        t = g ? req1_tag : req0_tag;
        if (!rs) begin
            chk("req0_ready", req0_ready, acc && !g);
            chk("req1_ready", req1_ready, acc && g);
            chk("rsp_valid", rsp_valid, s3);
            chk("busy", busy, stg.size() > 0);
            chk("stall_cnt", stall_cnt, m_stall);
            if (acc) begin
                chk("dp_a", dp_a, a);
                chk("dp_b", dp_b, b);
            end
            if (!any) chk("dp_a_idle", dp_a, 0);
        end
        @(posedge clk);
        acc0_q = acc && !g;
        acc1_q = acc && g;
        if (rs) begin
            stg.delete(); sb.delete(); m_prio = 1'b0; m_stall = 0;
        end else if (fl) begin
            stg.delete(); sb.delete();
        end else begin
            if (any && !acc && m_stall < STALL_MAX) m_stall++;
            occ[1] = 0; occ[2] = 0; occ[3] = 0;
            foreach (stg[i]) begin
                if (stg[i] == 3) begin
                    if (!rr) begin nq.push_back(3); occ[3] = 1; end
                end else if (!occ[stg[i] + 1]) begin
                    nq.push_back(stg[i] + 1); occ[stg[i] + 1] = 1;
                end else begin
                    nq.push_back(stg[i]); occ[stg[i]] = 1;
                end
            end
            stg = nq;
            if (acc) begin
                stg.push_back(1);
                sb.push_back('{q: fmul(a, b), id: g, tag: t});
                m_prio = !g;
            end
        end
        @(negedge clk);
    endtask

    task automatic new_op0(); req0_a = rand_fp(); req0_b = rand_fp(); req0_tag = TAG_W'($urandom); endtask
    task automatic new_op1(); req1_a = rand_fp(); req1_b = rand_fp(); req1_tag = TAG_W'($urandom); endtask

    task automatic drain(input int n);
        req0_valid = 0; req1_valid = 0; flush = 0; rsp_ready = 1;
        repeat (n) tick();
    endtask

    // Keep both requesters asserting; replace an operation once it is taken.
    task automatic both_busy(input int n);
        req0_valid = 1; req1_valid = 1;
        repeat (n) begin
            tick();
            if (acc0_q) new_op0();
            if (acc1_q) new_op1();
        end
    endtask

    initial begin
        int n;
        rst = 1; flush = 0; rsp_ready = 0;
        req0_valid = 0; req1_valid = 0;
        new_op0(); new_op1();
        acc0_q = 0; acc1_q = 0;
        m_prio = 0; m_stall = 0;
        tick(); tick();
        rst = 0;
        #1;
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_q", rsp_q, 0);
        chk("reset_rsp_id", rsp_id, 0);
        chk("reset_rsp_tag", rsp_tag, 0);
        chk("reset_busy", busy, 0);
        chk("reset_stall", stall_cnt, 0);

        // Single op: 2.0 * 3.0 = 6.0, result three cycles after acceptance.
        rsp_ready = 1;
        req0_valid = 1; req0_a = 32'h40000000; req0_b = 32'h40400000; req0_tag = 4'd3;
        tick();
        chk("single_accept", acc0_q, 1);
        req0_valid = 0;
        tick(); tick();
        chk("single_rsp_valid", rsp_valid, 1);
        chk("single_rsp_q", rsp_q, 32'h40C00000);
        chk("single_rsp_id", rsp_id, 0);
        chk("single_rsp_tag", rsp_tag, 3);
        drain(3);

        // Alternation: req0 was granted last, so req1 wins the first tie.
        new_op0(); new_op1();
        req0_valid = 1; req1_valid = 1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("alt_grant", {acc1_q, acc0_q}, (i % 2 == 0) ? 2'b10 : 2'b01);
            if (acc0_q) new_op0();
            if (acc1_q) new_op1();
        end
        drain(4);

        // Backpressure: fill, hold output for 5 cycles, then drain.
        rsp_ready = 0;
        both_busy(3);
        n = m_stall;
        for (int i = 0; i < 5; i++) begin
            both_busy(1);
            chk("bp_rsp_hold", rsp_q, sb[0].q);
        end
        chk("bp_stall_delta", stall_cnt, n + 5);
        drain(4);

        // Bubble collapse: op, idle, op with the output stalled.
        rsp_ready = 0;
        new_op0(); req0_valid = 1; tick();
        req0_valid = 0; tick();
        new_op0(); req0_valid = 1; tick();
        req0_valid = 0; tick();
        chk("bubble_en_s1", en_s1, 1);
        chk("bubble_en_s2", en_s2, 0);
        chk("bubble_rsp_valid", rsp_valid, 1);
        drain(4);

        // Flush with three in flight, then a fresh op: 1.5 * -2.0 = -3.0.
        rsp_ready = 0;
        req0_valid = 1;
        repeat (3) begin tick(); new_op0(); end
        req0_valid = 0; flush = 1; tick(); flush = 0;
        chk("flush_rsp_valid", rsp_valid, 0);
        chk("flush_busy", busy, 0);
        req1_valid = 1; req1_a = 32'h3FC00000; req1_b = 32'hC0000000; req1_tag = 4'd9;
        tick();
        req1_valid = 0; rsp_ready = 1;
        n = 0;
        while (!rsp_valid && n < 8) begin tick(); n++; end
        chk("flush_new_latency", n, 2);
        chk("flush_new_q", rsp_q, 32'hC0400000);
        chk("flush_new_id", rsp_id, 1);
        chk("flush_new_tag", rsp_tag, 9);
        drain(3);

        // Random traffic with random backpressure and occasional flush.
        for (int i = 0; i < 300; i++) begin
            if (!req0_valid || acc0_q) begin req0_valid = ($urandom_range(99) < 60); new_op0(); end
            if (!req1_valid || acc1_q) begin req1_valid = ($urandom_range(99) < 60); new_op1(); end
            rsp_ready = ($urandom_range(99) < 70);
            flush = ($urandom_range(39) == 0);
            tick();
        end
        drain(5);

        // Reset in the middle of traffic.
        rsp_ready = 0;
        both_busy(4);
        rst = 1; tick(); rst = 0;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_q", rsp_q, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_tag", rsp_tag, 0);
        chk("rst_busy", busy, 0);
        chk("rst_stall", stall_cnt, 0);
        rsp_ready = 1;
        new_op0(); new_op1();
        both_busy(1);
        chk("rst_ptr_req0", acc0_q, 1);
        drain(4);

        // Saturation of the stall counter.
        rsp_ready = 0;
        both_busy(45);
        chk("stall_saturate", stall_cnt, STALL_MAX);
        drain(6);

        chk("sb_leftover", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
